// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter.
// FSM states, requester ids and the access-size encoding.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_e;

    // Same encoding the decoder drives onto mem_size.
    localparam logic [1:0] SZ_INV = 2'd0;
    localparam logic [1:0] SZ_B   = 2'd1;
    localparam logic [1:0] SZ_H   = 2'd2;
    localparam logic [1:0] SZ_W   = 2'd3;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    function automatic logic size_ok(input logic [1:0] sz);
        logic ok;
        ok = 1'b0;
        unique case (sz)
            SZ_INV:           ok = 1'b0;
            SZ_B, SZ_H, SZ_W: ok = 1'b1;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_arbiter_timeout.sv
// Bus-cycle watchdog: counts BUSY cycles since the grant.
// expired_o fires in the TIMEOUT-th enabled cycle.
module mem_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the CPU and the debug/loader port
// onto a single request/ack memory bus, with a bus watchdog.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [1:0]  core_size,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_ack,
    output logic        core_err,
    output logic        core_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [1:0]  dbg_size,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_ack,
    output logic        dbg_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    state_e      state_q;
    owner_e      owner_q;
    owner_e      last_q;
    logic        mem_req_q;
    mreq_t       mem_q;
    logic [31:0] core_rdata_q;
    logic        core_ack_q;
    logic        core_err_q;
    logic [31:0] dbg_rdata_q;
    logic        dbg_ack_q;
    logic        dbg_err_q;

    logic        busy;
    logic        expired;
    logic        gnt_d;
    owner_e      win_d;
    mreq_t       pick_d;
    logic        resp_d;
    owner_e      resp_own_d;
    logic        resp_err_d;
    logic [31:0] resp_data_d;

    assign busy = (state_q == ST_BUSY);

    always_comb begin
        win_d = OWN_CORE;
        if (core_req && dbg_req) begin
            win_d = (last_q == OWN_DBG) ? OWN_CORE : OWN_DBG;
        end else if (!core_req) begin
            win_d = OWN_DBG;
        end
        gnt_d = (state_q == ST_IDLE) && (core_req || dbg_req);
        if (win_d == OWN_CORE) begin
            pick_d = '{core_we, core_size, core_addr, core_wdata};
        end else begin
            pick_d = '{dbg_we, dbg_size, dbg_addr, dbg_wdata};
        end
    end

    // An ack in the expiry cycle still counts as a normal completion.
    always_comb begin
        resp_d      = 1'b0;
        resp_own_d  = owner_q;
        resp_err_d  = 1'b0;
        resp_data_d = '0;
        unique case (1'b1)
            gnt_d && !size_ok(pick_d.size): begin
                resp_d     = 1'b1;
                resp_own_d = win_d;
                resp_err_d = 1'b1;
            end
            busy && mem_ack: begin
                resp_d      = 1'b1;
                resp_data_d = mem_rdata;
            end
            busy && !mem_ack && expired: begin
                resp_d     = 1'b1;
                resp_err_d = 1'b1;
            end
            default: ;
        endcase
    end

    mem_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (gnt_d),
        .enable_i  (busy),
        .expired_o (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_CORE;
            last_q       <= OWN_DBG;
            mem_req_q    <= 1'b0;
            mem_q        <= '0;
            core_rdata_q <= '0;
            core_ack_q   <= 1'b0;
            core_err_q   <= 1'b0;
            dbg_rdata_q  <= '0;
            dbg_ack_q    <= 1'b0;
            dbg_err_q    <= 1'b0;
        end else begin
            core_ack_q <= 1'b0;
            core_err_q <= 1'b0;
            dbg_ack_q  <= 1'b0;
            dbg_err_q  <= 1'b0;
            if (resp_d) begin
                if (resp_own_d == OWN_CORE) begin
                    core_ack_q   <= 1'b1;
                    core_err_q   <= resp_err_d;
                    core_rdata_q <= resp_data_d;
                end else begin
                    dbg_ack_q   <= 1'b1;
                    dbg_err_q   <= resp_err_d;
                    dbg_rdata_q <= resp_data_d;
                end
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (gnt_d) begin
                        owner_q <= win_d;
                        last_q  <= win_d;
                        mem_q   <= pick_d;
                        if (size_ok(pick_d.size)) begin
                            mem_req_q <= 1'b1;
                            state_q   <= ST_BUSY;
                        end else begin
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_BUSY: begin
                    if (resp_d) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_RESP;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign core_rdata = core_rdata_q;
    assign core_ack   = core_ack_q;
    assign core_err   = core_err_q;
    assign core_stall = rst_n && core_req && !core_ack_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign dbg_ack    = dbg_ack_q;
    assign dbg_err    = dbg_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_q.we;
    assign mem_size   = mem_q.size;
    assign mem_addr   = mem_q.addr;
    assign mem_wdata  = mem_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with TIMEOUT=4.
// Each step drives inputs just after a rising edge and checks #1 later.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we;
    logic [1:0]  core_size;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_ack, core_err, core_stall;
    logic        dbg_req, dbg_we;
    logic [1:0]  dbg_size;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        dbg_ack, dbg_err;
    logic        mem_req, mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_size  (core_size),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_ack   (core_ack),
        .core_err   (core_err),
        .core_stall (core_stall),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_size   (dbg_size),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_rdata  (dbg_rdata),
        .dbg_ack    (dbg_ack),
        .dbg_err    (dbg_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_size   (mem_size),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic core_rd(input logic [1:0] sz, input logic [31:0] a);
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_size = sz;
        core_addr = a;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        core_req = 0; core_we = 0; core_size = 0;
        core_addr = 0; core_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_size = 0;
        dbg_addr = 0; dbg_wdata = 0;
        mem_rdata = 0; mem_ack = 0;
        tick(); tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_core_ack", core_ack, 0);
        chk("rst_dbg_ack", dbg_ack, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_core_rdata", core_rdata, 0);
        rst_n = 1'b1;
        tick();

        // core word read, ack on third mem_req cycle
        core_rd(2'd3, 32'h100);
        #1;
        chk("rd_stall_req", core_stall, 1);
        tick();
        chk("rd_mem_req1", mem_req, 1);
        chk("rd_mem_addr", mem_addr, 32'h100);
        chk("rd_mem_size", mem_size, 3);
        chk("rd_mem_we", mem_we, 0);
        tick();
        chk("rd_mem_req2", mem_req, 1);
        tick();
        chk("rd_mem_req3", mem_req, 1);
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("rd_no_early_ack", core_ack, 0);
        chk("rd_stall_busy", core_stall, 1);
        tick();
        mem_ack = 0;
        chk("rd_core_ack", core_ack, 1);
        chk("rd_core_rdata", core_rdata, 32'hDEADBEEF);
        chk("rd_core_err", core_err, 0);
        chk("rd_mem_req_drop", mem_req, 0);
        chk("rd_stall_ack", core_stall, 0);
        chk("rd_dbg_ack", dbg_ack, 0);
        core_req = 0;
        tick();
        chk("rd_ack_pulse", core_ack, 0);
        chk("rd_rdata_hold", core_rdata, 32'hDEADBEEF);
        mem_ack = 1; mem_rdata = 32'h55555555;
        tick();
        mem_ack = 0;
        tick();
        chk("idle_ack_ign", core_ack, 0);
        chk("idle_rdata_ign", core_rdata, 32'hDEADBEEF);
        chk("idle_no_req", mem_req, 0);

        // round robin from reset: core, dbg, core
        rst_n = 0;
        tick();
        rst_n = 1;
        core_rd(2'd3, 32'h200);
        dbg_req = 1; dbg_we = 0; dbg_size = 3; dbg_addr = 32'h300;
        tick();
        chk("rr1_addr", mem_addr, 32'h200);
        mem_ack = 1; mem_rdata = 32'h11111111;
        tick();
        mem_ack = 0;
        chk("rr1_core_ack", core_ack, 1);
        chk("rr1_dbg_ack", dbg_ack, 0);
        chk("rr1_rdata", core_rdata, 32'h11111111);
        tick();
        chk("rr_resp_no_regrant", mem_req, 0);
        tick();
        chk("rr2_req", mem_req, 1);
        chk("rr2_addr", mem_addr, 32'h300);
        mem_ack = 1; mem_rdata = 32'h22222222;
        tick();
        mem_ack = 0;
        chk("rr2_dbg_ack", dbg_ack, 1);
        chk("rr2_core_ack", core_ack, 0);
        chk("rr2_dbg_rdata", dbg_rdata, 32'h22222222);
        chk("rr2_core_hold", core_rdata, 32'h11111111);
        tick();
        tick();
        chk("rr3_addr", mem_addr, 32'h200);
        mem_ack = 1; mem_rdata = 32'h33333333;
        tick();
        mem_ack = 0;
        chk("rr3_core_ack", core_ack, 1);
        core_req = 0; dbg_req = 0;
        tick();

        // debug byte write; mid-access field changes ignored
        dbg_req = 1; dbg_we = 1; dbg_size = 1;
        dbg_addr = 32'h3; dbg_wdata = 32'hAB;
        tick();
        chk("wr_req", mem_req, 1);
        chk("wr_we", mem_we, 1);
        chk("wr_size", mem_size, 1);
        chk("wr_addr", mem_addr, 32'h3);
        chk("wr_wdata", mem_wdata, 32'hAB);
        dbg_addr = 32'h99; dbg_wdata = 32'h77;
        tick();
        chk("wr_addr_stable", mem_addr, 32'h3);
        chk("wr_wdata_stable", mem_wdata, 32'hAB);
        mem_ack = 1; mem_rdata = 32'h5A5A5A5A;
        tick();
        mem_ack = 0;
        chk("wr_dbg_ack", dbg_ack, 1);
        chk("wr_dbg_err", dbg_err, 0);
        dbg_req = 0; dbg_we = 0;
        tick();

        // timeout without ack: four mem_req cycles then error
        core_rd(2'd3, 32'h400);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_req_c%0d", i + 1), mem_req, 1);
            chk($sformatf("to_noack_c%0d", i + 1), core_ack, 0);
            tick();
        end
        chk("to_req_drop", mem_req, 0);
        chk("to_ack", core_ack, 1);
        chk("to_err", core_err, 1);
        chk("to_rdata", core_rdata, 0);
        core_req = 0;
        tick();
        chk("to_ack_pulse", core_ack, 0);

        // ack in the expiry cycle wins
        core_rd(2'd3, 32'h404);
        tick();
        tick();
        tick();
        tick();
        chk("tw_req_c4", mem_req, 1);
        mem_ack = 1; mem_rdata = 32'hCAFE0004;
        tick();
        mem_ack = 0;
        chk("tw_ack", core_ack, 1);
        chk("tw_err", core_err, 0);
        chk("tw_rdata", core_rdata, 32'hCAFE0004);
        core_req = 0;
        tick();

        // invalid size: no bus cycle, immediate error
        core_rd(2'd0, 32'h500);
        tick();
        chk("inv_no_req", mem_req, 0);
        chk("inv_ack", core_ack, 1);
        chk("inv_err", core_err, 1);
        chk("inv_rdata", core_rdata, 0);
        core_req = 0;
        tick();
        chk("inv_no_req2", mem_req, 0);
        chk("inv_ack_pulse", core_ack, 0);

        // async reset mid-BUSY
        core_rd(2'd3, 32'h600);
        tick();
        chk("ar_busy", mem_req, 1);
        #2;
        rst_n = 0;
        #1;
        chk("ar_mem_req", mem_req, 0);
        chk("ar_mem_addr", mem_addr, 0);
        chk("ar_dbg_rdata", dbg_rdata, 0);
        chk("ar_stall", core_stall, 0);
        tick();
        chk("ar_no_ack", core_ack, 0);
        dbg_req = 1; dbg_we = 0; dbg_size = 3; dbg_addr = 32'h700;
        rst_n = 1;
        tick();
        chk("ar_restart_req", mem_req, 1);
        chk("ar_core_prio", mem_addr, 32'h600);
        mem_ack = 1; mem_rdata = 32'h600D600D;
        tick();
        mem_ack = 0;
        chk("ar_core_ack", core_ack, 1);
        chk("ar_core_rdata", core_rdata, 32'h600D600D);
        core_req = 0; dbg_req = 0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum number of mem_req cycles allowed without mem_ack (range 1..255).
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 core_req  input  1  CPU memory request; held with its fields stable until core_ack.
REQ-005 core_we, core_size, core_addr, core_wdata  input  1/2/32/32  write flag; size (1 byte, 2 half, 3 word, 0 invalid); byte address; store data.
REQ-006 core_rdata  output  32  load data; core_ack  output  1  one-cycle completion pulse; core_err  output  1  error flag, valid with core_ack.
REQ-007 core_stall  output  1  SHALL equal core_req AND NOT core_ack; it freezes the CPU T-state counter.
REQ-008 dbg_req, dbg_we, dbg_size, dbg_addr, dbg_wdata  input  1/1/2/32/32  debug/loader port, same semantics as the core port.
REQ-009 dbg_rdata  output  32; dbg_ack  output  1; dbg_err  output  1  same semantics as the core port.
REQ-010 mem_req, mem_we, mem_size, mem_addr, mem_wdata  output  1/1/2/32/32  memory request, held until mem_ack or timeout.
REQ-011 mem_rdata  input  32; mem_ack  input  1  memory completion, a one-cycle pulse.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-013 IDLE: if exactly one valid request is present, that requester SHALL be granted.
REQ-014 IDLE with both requests present: the requester not granted last SHALL win (round-robin).
REQ-015 On grant, the winner's we/size/addr/wdata SHALL be registered and the FSM SHALL move to BUSY.
REQ-016 mem_req and the registered fields SHALL be driven from the cycle after the grant.
REQ-017 Request at cycle N in IDLE SHALL give mem_req at N+1.
REQ-018 mem_ack at cycle M SHALL capture mem_rdata, deassert mem_req at M+1, and enter RESP at M+1.
REQ-019 RESP SHALL last exactly one cycle: the owner's ack is high, err=0, rdata holds the captured data; then IDLE.
REQ-020 Grants SHALL be made only in IDLE, so a request still high during RESP is not re-granted in that cycle.
REQ-021 A size==0 request SHALL be granted normally but SHALL NOT assert mem_req; the FSM SHALL go straight to RESP with err=1 and rdata=0.
REQ-022 The timeout counter SHALL clear on entering BUSY and increment each BUSY cycle.
REQ-023 Timeout: if the counter reaches TIMEOUT without mem_ack, mem_req SHALL drop and RESP SHALL follow with err=1 and rdata=0.
REQ-024 mem_ack in the same cycle the timeout is reached SHALL win (normal completion, err=0).
REQ-025 mem_ack outside BUSY SHALL be ignored.
REQ-026 rdata of the non-owner port SHALL hold its last value; the non-owner ack/err SHALL be 0.
REQ-027 Requester fields SHALL be sampled only at grant; changes during BUSY have no effect.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, last_grant=dbg, counter=0, and every output to 0, including rdata, ack, err and mem_*.
REQ-029 A reset during BUSY SHALL abort the access with no ack produced; after release, arbitration restarts with core priority.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, the owner enum (CORE, DBG) and the size constants (SZ_INV=0, SZ_B=1, SZ_H=2, SZ_W=3), which match the decoder's mem_size encoding.
REQ-031 The timeout counter SHALL be a sub-module mem_timeout (8-bit; inputs clear and enable; output expired).

Verification
REQ-032 Core word read at 0x100, mem_ack on the 3rd mem_req cycle returning 0xDEADBEEF -> core_ack exactly one cycle later, core_rdata=0xDEADBEEF, core_err=0, core_stall high until the ack.
REQ-033 core_req and dbg_req both raised in the first cycle after reset -> core served first, then dbg; with both held continuously -> grants alternate core, dbg, core.
REQ-034 dbg write, size 1, addr 0x3, wdata 0xAB -> mem_we=1, mem_size=1, mem_addr=0x3, mem_wdata=0xAB while mem_req is high; dbg_ack after mem_ack.
REQ-035 TIMEOUT=4 with no mem_ack -> mem_req high exactly 4 cycles, then ack with err=1 and rdata=0; also mem_ack on the 4th cycle -> err=0.
REQ-036 core size=0 -> mem_req never asserts; core_ack one cycle after the grant with core_err=1.
REQ-037 rst_n pulled low mid-BUSY -> all outputs 0 asynchronously, no ack; a new request after release completes normally.
